// File: rtl/arb_pkg.sv
// Shared types for the four-way round-robin port arbiter.
package arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request after last_winner, wrapping.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  req_idx_t        last_winner,
    output logic            any,
    output req_idx_t        idx
);

    req_idx_t cand;

    // Scan farthest-first so the nearest set request overwrites the result.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = last_winner + req_idx_t'(i);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/shared_port_arbiter4.sv
// Round-robin owner sequencing for a shared 32-bit resource port.
module shared_port_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_LOCK = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] lock,
    input  logic            done,
    output logic [NREQ-1:0] grant,
    output req_idx_t        sel,
    output logic            gnt_valid,
    output logic            start,
    output logic            timeout_err
);

    localparam int LCW = $clog2(MAX_LOCK) + 1;
    localparam int WDW = $clog2(TIMEOUT) + 1;

    arb_state_t     state;
    req_idx_t       last_winner;
    logic [LCW-1:0] lock_cnt;
    logic [WDW-1:0] wd_cnt;

    logic     pick_any;
    req_idx_t pick_idx;

    rr_pick u_pick (
        .req         (req),
        .last_winner (last_winner),
        .any         (pick_any),
        .idx         (pick_idx)
    );

    // sel doubles as the owner index while BUSY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= '0;
            sel         <= '0;
            gnt_valid   <= 1'b0;
            start       <= 1'b0;
            timeout_err <= 1'b0;
            last_winner <= req_idx_t'(NREQ - 1);
            lock_cnt    <= '0;
            wd_cnt      <= '0;
        end else begin
            start       <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        state       <= BUSY;
                        grant       <= NREQ'(1) << pick_idx;
                        sel         <= pick_idx;
                        gnt_valid   <= 1'b1;
                        start       <= 1'b1;
                        last_winner <= pick_idx;
                        lock_cnt    <= '0;
                        wd_cnt      <= '0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        if (lock[sel] && req[sel] &&
                            lock_cnt < LCW'(MAX_LOCK - 1)) begin
                            start    <= 1'b1;
                            lock_cnt <= lock_cnt + 1'b1;
                            wd_cnt   <= '0;
                        end else begin
                            state     <= IDLE;
                            grant     <= '0;
                            gnt_valid <= 1'b0;
                        end
                    end else if (!req[sel]) begin
                        state     <= IDLE;
                        grant     <= '0;
                        gnt_valid <= 1'b0;
                    end else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
                        state       <= IDLE;
                        grant       <= '0;
                        gnt_valid   <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_port_arbiter4.sv
// Directed bench for shared_port_arbiter4.
module tb_shared_port_arbiter4;
    import arb_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic       done;
    logic [3:0] grant;
    req_idx_t   sel;
    logic       gnt_valid;
    logic       start;
    logic       timeout_err;

    int checks = 0;
    int failures = 0;

    shared_port_arbiter4 #(
        .MAX_LOCK (4),
        .TIMEOUT  (64)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .lock        (lock),
        .done        (done),
        .grant       (grant),
        .sel         (sel),
        .gnt_valid   (gnt_valid),
        .start       (start),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req     = '0;
        lock    = '0;
        done    = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({grant, sel, gnt_valid, start, timeout_err} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0",
                     {grant, sel, gnt_valid, start, timeout_err});
        end
    endtask

    task automatic test_basic();
        do_reset();
        req = 4'b0101;
        step();
        checks++;
        if ({grant, sel, start, gnt_valid} !== {4'b0001, 2'd0, 2'b11}) begin
            failures++;
            $display("FAIL basic_first got g=%b s=%0d st=%b v=%b want g=0001 s=0 st=1 v=1",
                     grant, sel, start, gnt_valid);
        end
        step();
        checks++;
        if (start !== 1'b0 || grant !== 4'b0001) begin
            failures++;
            $display("FAIL basic_hold got g=%b st=%b want g=0001 st=0", grant, start);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (grant !== 4'b0000 || gnt_valid !== 1'b0 || sel !== 2'd0) begin
            failures++;
            $display("FAIL basic_bubble got g=%b v=%b s=%0d want g=0000 v=0 s=0",
                     grant, gnt_valid, sel);
        end
        step();
        checks++;
        if (grant !== 4'b0100 || sel !== 2'd2 || start !== 1'b1) begin
            failures++;
            $display("FAIL basic_second got g=%b s=%0d st=%b want g=0100 s=2 st=1",
                     grant, sel, start);
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if (grant !== exp_g[n] || start !== 1'b1) begin
                failures++;
                $display("FAIL rr_grant%0d got g=%b st=%b want g=%b st=1",
                         n, grant, start, exp_g[n]);
            end
            step();
            step();
            done = 1'b1;
            step();
            done = 1'b0;
            checks++;
            if (grant !== 4'b0000 || gnt_valid !== 1'b0) begin
                failures++;
                $display("FAIL rr_bubble%0d got g=%b v=%b want g=0000 v=0",
                         n, grant, gnt_valid);
            end
        end
        req = '0;
        step();
    endtask

    task automatic test_lock();
        int starts;
        do_reset();
        req  = 4'b0010;
        lock = 4'b0010;
        step();
        starts = int'(start);
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL lock_first got g=%b want 0010", grant);
        end
        req = 4'b0011;
        for (int n = 0; n < 3; n++) begin
            done = 1'b1;
            step();
            done = 1'b0;
            starts += int'(start);
            checks++;
            if (grant !== 4'b0010 || start !== 1'b1) begin
                failures++;
                $display("FAIL lock_again%0d got g=%b st=%b want g=0010 st=1",
                         n, grant, start);
            end
        end
        checks++;
        if (starts !== 4) begin
            failures++;
            $display("FAIL lock_starts got=%0d want=4", starts);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (grant !== 4'b0000 || start !== 1'b0) begin
            failures++;
            $display("FAIL lock_release got g=%b st=%b want g=0000 st=0", grant, start);
        end
        step();
        checks++;
        if (grant !== 4'b0001 || start !== 1'b1) begin
            failures++;
            $display("FAIL lock_next got g=%b st=%b want g=0001 st=1", grant, start);
        end
        req  = '0;
        lock = '0;
        step();
        step();
    endtask

    task automatic test_timeout();
        int early;
        do_reset();
        req = 4'b0100;
        step();
        checks++;
        if (grant !== 4'b0100 || start !== 1'b1) begin
            failures++;
            $display("FAIL wd_grant got g=%b st=%b want g=0100 st=1", grant, start);
        end
        early = 0;
        for (int n = 1; n < 64; n++) begin
            step();
            if (timeout_err !== 1'b0 || grant !== 4'b0100) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL wd_early got=%0d bad cycles want=0", early);
        end
        step();
        checks++;
        if (timeout_err !== 1'b1 || grant !== 4'b0000) begin
            failures++;
            $display("FAIL wd_fire got err=%b g=%b want err=1 g=0000",
                     timeout_err, grant);
        end
        req = '0;
        step();
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL wd_pulse got err=%b want 0", timeout_err);
        end
    endtask

    task automatic test_done_abort();
        do_reset();
        req = 4'b0001;
        step();
        step();
        done = 1'b1;
        req  = '0;
        step();
        done = 1'b0;
        checks++;
        if (grant !== 4'b0000 || timeout_err !== 1'b0 || start !== 1'b0) begin
            failures++;
            $display("FAIL done_abort got g=%b err=%b st=%b want 0000/0/0",
                     grant, timeout_err, start);
        end
        req = 4'b0010;
        step();
        step();
        req = '0;
        step();
        checks++;
        if (grant !== 4'b0000 || start !== 1'b0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL abort got g=%b st=%b err=%b want 0000/0/0",
                     grant, start, timeout_err);
        end
        step();
        checks++;
        if (grant !== 4'b0000 || start !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got g=%b st=%b want 0000/0", grant, start);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || gnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_rst got g=%b v=%b want 0000/0", grant, gnt_valid);
        end
        req = 4'b1111;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0001 || sel !== 2'd0) begin
            failures++;
            $display("FAIL async_first got g=%b s=%0d want 0001/0", grant, sel);
        end
        req = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_lock();
        test_timeout();
        test_done_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

endmodule
